frame_ptr_mgr: RTL

// - Single-clock frame-slot manager for an N-frame DDR video buffer.
// - Hands base addresses to the frame writer and reader, tracks each slot's state, and decides drop/repeat.
// - Sits between frame_wr_ctrl and frame_rd_ctrl when both run on one clock.
// - Generalises fixed triple-buffering to any FRAMES_AMOUNT, with selectable read mode.

---
 rtl/frame_ptr_mgr.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/frame_ptr_mgr.sv
// frame_ptr_mgr: single-clock frame-slot manager for an N-frame video buffer.
// Hands slot base addresses to the frame writer and reader, tracks per-slot
// state (FREE/WRITING/READY/READING) with a wrap-safe sequence stamp, and
// decides frame drop (writer overwrites oldest READY) and repeat (reader
// re-granted its held slot).
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   wr_req_i, wr_done_i             writer start-of-frame / end-of-frame pulses
//   wr_grant_o, wr_addr_o, wr_idx_o registered write grant (1 cycle after req)
//   rd_req_i                        reader next-frame pulse
//   rd_grant_o, rd_addr_o, rd_idx_o registered read grant (1 cycle after req)
//   rd_repeat_o, rd_empty_o         read grant flags
//   frames_ready_o                  number of READY slots (registered)
//   drop_cnt_o, repeat_cnt_o        saturating statistics, only with
//                                   FRAME_PTR_MGR_STATS_EN defined
//
// Optional feature macro: FRAME_PTR_MGR_STATS_EN

module frame_ptr_mgr #(
  parameter longint unsigned START_ADDR    = 64'd0,
  parameter int unsigned     FRAMES_AMOUNT = 3,
  parameter longint unsigned FRAME_SIZE_B  = 64'h40_0000,
  parameter int unsigned     ADDR_WIDTH    = 32,
  parameter int unsigned     RD_MODE       = 0,
  parameter int unsigned     SEQ_WIDTH     = 8,
  localparam int unsigned    IDX_W         = $clog2(FRAMES_AMOUNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_req_i,
  input  logic                  wr_done_i,
  output logic                  wr_grant_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [IDX_W-1:0]      wr_idx_o,
  input  logic                  rd_req_i,
  output logic                  rd_grant_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [IDX_W-1:0]      rd_idx_o,
  output logic                  rd_repeat_o,
  output logic                  rd_empty_o,
  output logic [IDX_W:0]        frames_ready_o
`ifdef FRAME_PTR_MGR_STATS_EN
  ,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           repeat_cnt_o
`endif
);

  localparam int unsigned CNT_W = IDX_W + 1;

  // Parameter sanity checks at elaboration
  if (FRAMES_AMOUNT < 3) begin : g_bad_frames
    $error("frame_ptr_mgr: FRAMES_AMOUNT must be >= 3");
  end
  if (SEQ_WIDTH <= IDX_W + 1) begin : g_bad_seq
    $error("frame_ptr_mgr: SEQ_WIDTH must exceed clog2(FRAMES_AMOUNT)+1");
  end

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_WRITING = 2'd1,
    S_READY   = 2'd2,
    S_READING = 2'd3
  } slot_state_t;

  slot_state_t          st_q    [FRAMES_AMOUNT];
  slot_state_t          st_n    [FRAMES_AMOUNT];
  logic [SEQ_WIDTH-1:0] stamp_q [FRAMES_AMOUNT];
  logic [SEQ_WIDTH-1:0] stamp_n [FRAMES_AMOUNT];
  logic [SEQ_WIDTH-1:0] seq_q, seq_n;

  logic                 wr_gnt_n, rd_gnt_n, rd_rep_n, rd_emp_n;
  logic [IDX_W-1:0]     wr_idx_n, rd_idx_n;
  logic                 rd_found, wr_found, wr_drop;
  logic [SEQ_WIDTH-1:0] rd_best, wr_best;
  logic [FRAMES_AMOUNT-1:0] rd_freed;
  logic [CNT_W-1:0]     ready_cnt_n;
`ifdef FRAME_PTR_MGR_STATS_EN
  logic [CNT_W-1:0]     drop_inc_n;
`endif

  // Wrap-safe age compare: a older than b when signed(a - b) < 0
  function automatic logic older(input logic [SEQ_WIDTH-1:0] a,
                                 input logic [SEQ_WIDTH-1:0] b);
    logic [SEQ_WIDTH-1:0] d;
    d = a - b;
    return d[SEQ_WIDTH-1];
  endfunction

  // Slot base address, computed in 64 bits then truncated
  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [IDX_W-1:0] idx);
    logic [63:0] full;
    full = 64'(START_ADDR) + 64'(idx) * 64'(FRAME_SIZE_B);
    return ADDR_WIDTH'(full);
  endfunction

  // Next-state: apply done, then resolve read, then pick the write slot
  always_comb begin
    st_n        = st_q;
    stamp_n     = stamp_q;
    seq_n       = seq_q;
    wr_gnt_n    = 1'b0;
    wr_idx_n    = '0;
    rd_gnt_n    = 1'b0;
    rd_idx_n    = '0;
    rd_rep_n    = 1'b0;
    rd_emp_n    = 1'b0;
    rd_found    = 1'b0;
    wr_found    = 1'b0;
    wr_drop     = 1'b0;
    rd_best     = '0;
    wr_best     = '0;
    rd_freed    = '0;
    ready_cnt_n = '0;
`ifdef FRAME_PTR_MGR_STATS_EN
    drop_inc_n  = '0;
`endif

    if (wr_done_i) begin
      for (int i = 0; i < FRAMES_AMOUNT; i++) begin
        if (st_q[i] == S_WRITING) begin
          st_n[i]    = S_READY;
          stamp_n[i] = seq_q;
          seq_n      = seq_q + SEQ_WIDTH'(1);
        end
      end
    end

    if (rd_req_i) begin
      rd_gnt_n = 1'b1;
      for (int i = 0; i < FRAMES_AMOUNT; i++) begin
        if (st_n[i] == S_READY) begin
          if (!rd_found ||
              ((RD_MODE == 0) ? older(rd_best, stamp_n[i]) : older(stamp_n[i], rd_best))) begin
            rd_idx_n = IDX_W'(i);
            rd_best  = stamp_n[i];
          end
          rd_found = 1'b1;
        end
      end
      if (rd_found) begin
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
          if (IDX_W'(i) == rd_idx_n) begin
            st_n[i] = S_READING;
          end else if (st_n[i] == S_READING) begin
            st_n[i]     = S_FREE;
            rd_freed[i] = 1'b1;
          end else if ((RD_MODE == 0) && (st_n[i] == S_READY) && older(stamp_n[i], rd_best)) begin
            // Newest-first reader skips everything older than what it took
            st_n[i]     = S_FREE;
            rd_freed[i] = 1'b1;
`ifdef FRAME_PTR_MGR_STATS_EN
            drop_inc_n  = drop_inc_n + CNT_W'(1);
`endif
          end
        end
      end else begin
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
          if (st_n[i] == S_READING) begin
            rd_idx_n = IDX_W'(i);
            rd_rep_n = 1'b1;
          end
        end
        rd_emp_n = !rd_rep_n;
      end
    end

    if (wr_req_i) begin
      // An unfinished frame is abandoned
      for (int i = 0; i < FRAMES_AMOUNT; i++) begin
        if (st_n[i] == S_WRITING) st_n[i] = S_FREE;
      end
      for (int i = 0; i < FRAMES_AMOUNT; i++) begin
        if (!wr_found && (st_n[i] == S_FREE) && !rd_freed[i]) begin
          wr_found = 1'b1;
          wr_idx_n = IDX_W'(i);
        end
      end
      if (!wr_found) begin
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
          if ((st_n[i] == S_READY) && (!wr_drop || older(stamp_n[i], wr_best))) begin
            wr_drop  = 1'b1;
            wr_idx_n = IDX_W'(i);
            wr_best  = stamp_n[i];
          end
        end
        wr_found = wr_drop;
      end
      // Last resort: reuse a slot the reader just released
      if (!wr_found) begin
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
          if (!wr_found && (st_n[i] == S_FREE)) begin
            wr_found = 1'b1;
            wr_idx_n = IDX_W'(i);
          end
        end
      end
      if (wr_found) begin
        wr_gnt_n = 1'b1;
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
          if (IDX_W'(i) == wr_idx_n) st_n[i] = S_WRITING;
        end
`ifdef FRAME_PTR_MGR_STATS_EN
        if (wr_drop) drop_inc_n = drop_inc_n + CNT_W'(1);
`endif
      end
    end

    for (int i = 0; i < FRAMES_AMOUNT; i++) begin
      if (st_n[i] == S_READY) ready_cnt_n = ready_cnt_n + CNT_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FRAMES_AMOUNT; i++) begin
        st_q[i]    <= S_FREE;
        stamp_q[i] <= '0;
      end
      seq_q          <= '0;
      wr_grant_o     <= 1'b0;
      wr_addr_o      <= '0;
      wr_idx_o       <= '0;
      rd_grant_o     <= 1'b0;
      rd_addr_o      <= '0;
      rd_idx_o       <= '0;
      rd_repeat_o    <= 1'b0;
      rd_empty_o     <= 1'b0;
      frames_ready_o <= '0;
    end else begin
      st_q           <= st_n;
      stamp_q        <= stamp_n;
      seq_q          <= seq_n;
      wr_grant_o     <= wr_gnt_n;
      rd_grant_o     <= rd_gnt_n;
      rd_repeat_o    <= rd_rep_n;
      rd_empty_o     <= rd_emp_n;
      frames_ready_o <= ready_cnt_n;
      if (wr_gnt_n) begin
        wr_addr_o <= slot_addr(wr_idx_n);
        wr_idx_o  <= wr_idx_n;
      end
      if (rd_gnt_n) begin
        rd_addr_o <= slot_addr(rd_idx_n);
        rd_idx_o  <= rd_idx_n;
      end
    end
  end

`ifdef FRAME_PTR_MGR_STATS_EN
  logic [16:0] drop_sum;
  assign drop_sum = 17'(drop_cnt_o) + 17'(drop_inc_n);

  // Saturating drop / repeat statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_o   <= '0;
      repeat_cnt_o <= '0;
    end else begin
      drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (rd_rep_n && (repeat_cnt_o != 16'hFFFF)) begin
        repeat_cnt_o <= repeat_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule
